// File: rtl/ysyx_22040127_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode into a two-entry elastic buffer (head + skid).
// Define DECODE_PERF_CNT_EN to add the delivered/stall performance counters and their ports.
module ysyx_22040127_decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_reg_wen,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_dec_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        T_I   = 3'd0,
        T_U   = 3'd1,
        T_S   = 3'd2,
        T_J   = 3'd3,
        T_R   = 3'd4,
        T_B   = 3'd5,
        T_N   = 3'd6,
        T_ILL = 3'd7
    } inst_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        inst_type_e      itype;
        logic            reg_wen;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_W  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_W  = 7'b0111011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam bit IS_RV32 = (XLEN == 32);

    if (CNT_W < 1 || (XLEN != 32 && XLEN != 64)) begin : g_cfg_check
        $error("decode_stage: XLEN must be 32 or 64 and CNT_W positive");
    end

    // ---------------- decode ----------------
    entry_t      dec;
    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = in_inst[6:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec     = '0;
        imm32   = '0;
        dec.pc  = in_pc;
        dec.rd  = in_inst[11:7];
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];

        // Every legal opcode ends in 2'b11, so compressed encodings fall into the default.
        case (opcode)
            OP_LUI, OP_AUIPC:                 dec.itype = T_U;
            OP_IMM, OP_LOAD, OP_JALR:         dec.itype = T_I;
            OP_IMM_W:                         dec.itype = IS_RV32 ? T_ILL : T_I;
            OP_REG:                           dec.itype = T_R;
            OP_REG_W:                         dec.itype = IS_RV32 ? T_ILL : T_R;
            OP_JAL:                           dec.itype = T_J;
            OP_STORE:                         dec.itype = T_S;
            OP_BRANCH:                        dec.itype = T_B;
            OP_SYSTEM, OP_FENCE:              dec.itype = T_N;
            default:                          dec.itype = T_ILL;
        endcase

        case (dec.itype)
            T_I, T_N: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            T_U:      imm32 = {in_inst[31:12], 12'b0};
            T_S:      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_B:      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0};
            T_J:      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                               in_inst[20], in_inst[30:21], 1'b0};
            default:  imm32 = '0;
        endcase

        dec.imm       = XLEN'($signed(imm32));
        dec.illegal   = (dec.itype == T_ILL);
        dec.reg_wen   = (dec.itype inside {T_I, T_U, T_J, T_R}) && (dec.rd != 5'd0);
        dec.mem_read  = !dec.illegal && (opcode == OP_LOAD);
        dec.mem_write = !dec.illegal && (opcode == OP_STORE);
    end

    // ---------------- elastic buffer ----------------
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   push;
    logic   pop;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid_q;
    assign pop      = head_valid_q && out_ready;
    assign push     = in_valid && in_ready && !flush;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q || pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                head_d       = dec;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: the payload registers are reset too, because the outputs must read as zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = head_valid_q;
    assign out_pc        = head_q.pc;
    assign out_rd        = head_q.rd;
    assign out_rs1       = head_q.rs1;
    assign out_rs2       = head_q.rs2;
    assign out_imm       = head_q.imm;
    assign out_type      = head_q.itype;
    assign out_reg_wen   = head_q.reg_wen;
    assign out_mem_read  = head_q.mem_read;
    assign out_mem_write = head_q.mem_write;
    assign out_illegal   = head_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    logic [CNT_W-1:0] perf_dec_q, perf_dec_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_dec_d   = perf_dec_q + CNT_W'(pop);
        perf_stall_d = perf_stall_q + CNT_W'(head_valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_dec_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_dec_q   <= perf_dec_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_dec_cnt   = perf_dec_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22040127_decode_stage.sv
// Directed bench for the decode stage: XLEN=64 main instance plus an XLEN=32 instance for RV32 legality.
module tb_ysyx_22040127_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_reg_wen, out_mem_read, out_mem_write, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_type;

    logic        in_ready32, out_valid32, out_reg_wen32, out_mem_read32, out_mem_write32, out_illegal32;
    logic [31:0] out_pc32, out_imm32;
    logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
    logic [2:0]  out_type32;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_dec_cnt, perf_stall_cnt, perf_dec_cnt32, perf_stall_cnt32;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_dec = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    ysyx_22040127_decode_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_type(out_type), .out_reg_wen(out_reg_wen), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(perf_dec_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    ysyx_22040127_decode_stage #(.XLEN(32), .CNT_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_imm(out_imm32),
        .out_type(out_type32), .out_reg_wen(out_reg_wen32), .out_mem_read(out_mem_read32),
        .out_mem_write(out_mem_write32), .out_illegal(out_illegal32)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(perf_dec_cnt32), .perf_stall_cnt(perf_stall_cnt32)
`endif
    );

    // One clock: update the expected perf counts from the pre-edge handshake, then sample 1ns after the edge.
    task automatic tick();
        if (out_valid && out_ready) exp_dec++;
        if (out_valid && !out_ready) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_pc !== 64'd0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        n_tests++; if (out_imm !== 64'd0) begin n_fail++; $display("FAIL reset_out_imm: got %h expected 0", out_imm); end
        n_tests++; if (out_type !== 3'd0) begin n_fail++; $display("FAIL reset_out_type: got %0d expected 0", out_type); end
        rst = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_addi_fields();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h0000_0000_8000_0000;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_rs2 !== 5'd5) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d rs2=%0d expected 1 0 5", out_rd, out_rs1, out_rs2); end
        n_tests++; if (out_pc !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL addi_pc: got %h expected 80000000", out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b expected 0", out_valid); end
        n_tests++; if (out_pc !== 64'h0000_0000_8000_0000 || out_imm !== 64'd5) begin n_fail++; $display("FAIL addi_payload_hold: got pc=%h imm=%h expected pc=80000000 imm=5", out_pc, out_imm); end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  t;
        logic [63:0] imm;
        logic        wen;
        logic        mr;
        logic        mw;
        logic        ill;
    } vec_t;

    task automatic test_decode_table();
        vec_t v[14];
        v[0]  = '{32'h00500093, 3'd0, 64'd5,                  1'b1, 1'b0, 1'b0, 1'b0}; // addi x1,x0,5
        v[1]  = '{32'h12345137, 3'd1, 64'h0000_0000_1234_5000, 1'b1, 1'b0, 1'b0, 1'b0}; // lui x2
        v[2]  = '{32'hFE000EE3, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0}; // beq -4
        v[3]  = '{32'h00512423, 3'd2, 64'd8,                  1'b0, 1'b0, 1'b1, 1'b0}; // sw x5,8(x2)
        v[4]  = '{32'hFF00B183, 3'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0}; // ld x3,-16(x1)
        v[5]  = '{32'h001000EF, 3'd3, 64'h800,                1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,2048
        v[6]  = '{32'h002081B3, 3'd4, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0}; // add x3,x1,x2
        v[7]  = '{32'h00000073, 3'd6, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0}; // ecall
        v[8]  = '{32'h00000013, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0}; // nop, rd=0
        v[9]  = '{32'h00000000, 3'd7, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b1}; // all zero
        v[10] = '{32'h00000001, 3'd7, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b1}; // low bits != 11
        v[11] = '{32'h0010009B, 3'd0, 64'd1,                  1'b1, 1'b0, 1'b0, 1'b0}; // addiw on RV64
        v[12] = '{32'h80000037, 3'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0, 1'b0}; // lui x0, sign
        v[13] = '{32'hFFF0000F, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0}; // fence, imm -1
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_inst = v[i].inst; in_pc = 64'h1000 + 64'(4 * i);
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL tbl%0d_in_ready: got %b expected 1", i, in_ready); end
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i)) begin n_fail++; $display("FAIL tbl%0d_head: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, 64'h1000 + 64'(4 * i)); end
            n_tests++; if (out_type !== v[i].t) begin n_fail++; $display("FAIL tbl%0d_type: got %0d expected %0d", i, out_type, v[i].t); end
            n_tests++; if (out_imm !== v[i].imm) begin n_fail++; $display("FAIL tbl%0d_imm: got %h expected %h", i, out_imm, v[i].imm); end
            n_tests++; if ({out_reg_wen, out_mem_read, out_mem_write, out_illegal} !== {v[i].wen, v[i].mr, v[i].mw, v[i].ill})
                begin n_fail++; $display("FAIL tbl%0d_ctrl: got wen/mr/mw/ill=%b%b%b%b expected %b%b%b%b", i, out_reg_wen, out_mem_read, out_mem_write, out_illegal, v[i].wen, v[i].mr, v[i].mw, v[i].ill); end
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tbl_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stall_base;
        logic [31:0] insts [3];
        insts[0] = 32'h00100093; insts[1] = 32'h00200113; insts[2] = 32'h00300193;
`ifdef DECODE_PERF_CNT_EN
        stall_base = perf_stall_cnt;
`else
        stall_base = '0;
`endif
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = insts[0]; in_pc = 64'h200;
        tick();
        in_inst = insts[1]; in_pc = 64'h204;
        tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
        in_inst = insts[2]; in_pc = 64'h208;
        repeat (3) tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_imm !== 64'd1 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL bp_hold: got valid=%b pc=%h imm=%h ready=%b expected 1 200 1 0", out_valid, out_pc, out_imm, in_ready); end
`ifdef DECODE_PERF_CNT_EN
        n_tests++; if (perf_stall_cnt - stall_base !== 32'd4) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 4", perf_stall_cnt - stall_base); end
`endif
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h204 || out_imm !== 64'd2 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL bp_second: got valid=%b pc=%h imm=%h ready=%b expected 1 204 2 1", out_valid, out_pc, out_imm, in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h208 || out_imm !== 64'd3)
            begin n_fail++; $display("FAIL bp_third: got valid=%b pc=%h imm=%h expected 1 208 3", out_valid, out_pc, out_imm); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        // Buffer full, flush while an input is offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00400213; in_pc = 64'h300;
        tick();
        in_pc = 64'h304;
        tick();
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_full: got ready=%b valid=%b expected 0 1", in_ready, out_valid); end
        flush = 1'b1; in_pc = 64'h308;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_full: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak_a: got valid=%b pc=%h expected valid 0", out_valid, out_pc); end
        // Head full, skid empty: the offered input would be accepted but flush drops it.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 64'h400;
        tick();
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_half: got valid=%b ready=%b expected 1 1", out_valid, in_ready); end
        flush = 1'b1; out_ready = 1'b1; in_pc = 64'h404;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_input: got valid=%b pc=%h expected valid 0", out_valid, out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak_b: got valid=%b pc=%h expected valid 0", out_valid, out_pc); end
    endtask

    task automatic test_xlen32();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0010009B; in_pc = 64'h500;
        tick();
        in_inst = 32'h80000037; in_pc = 64'h504;
        n_tests++; if (out_valid32 !== 1'b1 || out_illegal32 !== 1'b1 || out_type32 !== 3'd7 || out_imm32 !== 32'd0 || out_reg_wen32 !== 1'b0)
            begin n_fail++; $display("FAIL rv32_addiw: got valid=%b ill=%b type=%0d imm=%h wen=%b expected 1 1 7 0 0", out_valid32, out_illegal32, out_type32, out_imm32, out_reg_wen32); end
        n_tests++; if (out_illegal !== 1'b0 || out_type !== 3'd0 || out_imm !== 64'd1)
            begin n_fail++; $display("FAIL rv64_addiw: got ill=%b type=%0d imm=%h expected 0 0 1", out_illegal, out_type, out_imm); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_type32 !== 3'd1 || out_imm32 !== 32'h8000_0000 || out_pc32 !== 32'h504)
            begin n_fail++; $display("FAIL rv32_lui: got type=%0d imm=%h pc=%h expected 1 80000000 504", out_type32, out_imm32, out_pc32); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFF00B183; in_pc = 64'h600;
        tick();
        in_pc = 64'h604;
        tick();
        in_valid = 1'b0;
`ifdef DECODE_PERF_CNT_EN
        n_tests++; if (perf_dec_cnt !== 32'(exp_dec) || perf_stall_cnt !== 32'(exp_stall))
            begin n_fail++; $display("FAIL perf_totals: got dec=%0d stall=%0d expected %0d %0d", perf_dec_cnt, perf_stall_cnt, exp_dec, exp_stall); end
`endif
        #2 rst = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_hs: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        n_tests++; if (out_pc !== 64'd0 || out_imm !== 64'd0 || out_type !== 3'd0 || out_rd !== 5'd0 || out_rs1 !== 5'd0)
            begin n_fail++; $display("FAIL areset_payload: got pc=%h imm=%h type=%0d rd=%0d rs1=%0d expected all 0", out_pc, out_imm, out_type, out_rd, out_rs1); end
        n_tests++; if ({out_reg_wen, out_mem_read, out_mem_write, out_illegal} !== 4'b0000)
            begin n_fail++; $display("FAIL areset_ctrl: got %b%b%b%b expected 0000", out_reg_wen, out_mem_read, out_mem_write, out_illegal); end
`ifdef DECODE_PERF_CNT_EN
        n_tests++; if (perf_dec_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_perf: got dec=%0d stall=%0d expected 0 0", perf_dec_cnt, perf_stall_cnt); end
`endif
        exp_dec = 0; exp_stall = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release: got %b expected 0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h700;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_imm !== 64'd5 || out_pc !== 64'h700)
            begin n_fail++; $display("FAIL areset_resume: got valid=%b imm=%h pc=%h expected 1 5 700", out_valid, out_imm, out_pc); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi_fields();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_xlen32();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
